// File: rtl/driver_vga_palette.sv
// Palette-indexed framebuffer VGA driver: write-only command port, hardware clear
// engine, and an internally timed 640x480@60 raster with a two-tick colour pipeline.
module driver_vga_palette #(
    parameter int COLS  = 80,
    parameter int ROWS  = 60,
    parameter int BPP   = 1,
    parameter int SHIFT = 3
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        chip_select,
    input  logic        write_enable,
    output logic        busy,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int NPAL  = 1 << BPP;

    localparam logic [9:0]    H_VIS   = 10'd640;
    localparam logic [9:0]    H_SS    = 10'd656;
    localparam logic [9:0]    H_SE    = 10'd751;
    localparam logic [9:0]    H_LAST  = 10'd799;
    localparam logic [9:0]    V_VIS   = 10'd480;
    localparam logic [9:0]    V_SS    = 10'd490;
    localparam logic [9:0]    V_SE    = 10'd491;
    localparam logic [9:0]    V_LAST  = 10'd524;
    localparam logic [9:0]    COLS_W  = 10'(COLS);
    localparam logic [9:0]    ROWS_W  = 10'(ROWS);
    localparam logic [AW-1:0] LAST_A  = AW'(CELLS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // ---------------- command decode ----------------
    logic          w_strobe, w_row_ok, w_col_ok;
    logic          w_cmd_pix, w_cmd_pal, w_cmd_clear;
    logic [AW-1:0] w_pix_addr;
    logic          w_unused;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_addr;
    logic [BPP-1:0] r_fill;
    logic          w_clr_we;

    assign w_strobe    = chip_select & write_enable;
    assign w_row_ok    = int'(data[23:16]) < ROWS;
    assign w_col_ok    = int'(data[15:8]) < COLS;
    assign w_cmd_pix   = w_strobe && (data[31:30] == 2'b00) && w_row_ok && w_col_ok
                         && (r_state == S_IDLE);
    assign w_cmd_pal   = w_strobe && (data[31:30] == 2'b01);
    assign w_cmd_clear = w_strobe && (data[31:30] == 2'b10);
    assign w_pix_addr  = AW'(data[23:16]) * AW'(COLS) + AW'(data[15:8]);
    assign w_unused    = ^data[29:24];

    // ---------------- clear engine ----------------
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_cmd_clear) w_state_nxt = S_CLEAR;
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == LAST_A) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_clr_addr <= '0;
            r_fill     <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_cmd_clear) begin
                r_clr_addr <= '0;
                r_fill     <= data[BPP-1:0];
            end
        end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    assign busy = (r_state == S_CLEAR);

    // ---------------- framebuffer (dual port, not reset) ----------------
    logic [BPP-1:0] r_fb [CELLS];
    logic           w_fb_we;
    logic [AW-1:0]  w_fb_waddr;
    logic [BPP-1:0] w_fb_wdata;

    always_comb begin
        w_fb_we    = 1'b0;
        w_fb_waddr = r_clr_addr;
        w_fb_wdata = r_fill;
        if (w_clr_we) begin
            w_fb_we = 1'b1;
        end else if (w_cmd_pix) begin
            w_fb_we    = 1'b1;
            w_fb_waddr = w_pix_addr;
            w_fb_wdata = data[BPP-1:0];
        end
    end

    always_ff @(posedge clock_50) begin
        if (w_fb_we) r_fb[w_fb_waddr] <= w_fb_wdata;
    end

    // ---------------- palette ----------------
    logic [23:0] r_pal [NPAL];

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++) r_pal[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
        end else if (w_cmd_pal) begin
            r_pal[data[24 +: BPP]] <= data[23:0];
        end
    end

    // ---------------- raster ----------------
    // The first tick after reset only arms the raster and flags frame_start, so
    // pixel (0,0) is processed on the following tick like any other frame start.
    logic       r_vga_clk, r_run, r_frame_start;
    logic [9:0] r_h, r_v, w_h_nxt, w_v_nxt;
    logic       w_tick, w_adv;

    assign w_tick  = r_vga_clk;
    assign w_adv   = w_tick & r_run;
    assign w_h_nxt = (r_h == H_LAST) ? 10'd0 : r_h + 10'd1;
    assign w_v_nxt = (r_h != H_LAST) ? r_v : ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1);

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_vga_clk     <= 1'b0;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
        end else begin
            r_vga_clk     <= ~r_vga_clk;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                if (!r_run) begin
                    r_run         <= 1'b1;
                    r_frame_start <= 1'b1;
                end else begin
                    r_h           <= w_h_nxt;
                    r_v           <= w_v_nxt;
                    r_frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
                end
            end
        end
    end

    assign VGA_CLK     = r_vga_clk;
    assign frame_start = r_frame_start;
    assign VGA_SYNC    = 1'b0;

    // ---------------- display pipeline ----------------
    logic [9:0]    w_col, w_row;
    logic          w_border;
    logic [AW-1:0] w_rd_addr;
    logic [BPP-1:0] r_cell;
    logic          r_hs1, r_vs1, r_blank1, r_border1;
    logic          r_hs2, r_vs2, r_blank2;
    logic [23:0]   r_rgb;

    assign w_col     = r_h >> SHIFT;
    assign w_row     = r_v >> SHIFT;
    assign w_border  = (w_col >= COLS_W) || (w_row >= ROWS_W);
    assign w_rd_addr = w_border ? '0 : AW'(w_row) * AW'(COLS) + AW'(w_col);

    // Separate from the write process so a same-cycle collision reads the old cell.
    always_ff @(posedge clock_50) begin
        if (w_adv) r_cell <= r_fb[w_rd_addr];
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_blank1  <= 1'b0;
            r_border1 <= 1'b0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_blank2  <= 1'b0;
            r_rgb     <= '0;
        end else if (w_adv) begin
            r_hs1     <= !((r_h >= H_SS) && (r_h <= H_SE));
            r_vs1     <= !((r_v >= V_SS) && (r_v <= V_SE));
            r_blank1  <= (r_h < H_VIS) && (r_v < V_VIS);
            r_border1 <= w_border;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_blank2  <= r_blank1;
            r_rgb     <= (r_blank1 && !r_border1) ? r_pal[r_cell] : 24'h000000;
        end
    end

    assign VGA_HS    = r_hs2;
    assign VGA_VS    = r_vs2;
    assign VGA_BLANK = r_blank2;
    assign VGA_R     = r_rgb[23:16];
    assign VGA_G     = r_rgb[15:8];
    assign VGA_B     = r_rgb[7:0];

endmodule

// File: tb/tb_driver_vga_palette.sv
// Bench for driver_vga_palette: directed commands push expected pixel colours into
// queues; a raster monitor keyed on VGA_BLANK pops and compares them.
module tb_driver_vga_palette;
    logic clk, rst;

    logic [31:0] data1, data4;
    logic        cs1, we1, cs4, we4;
    logic        busy1, fs1, vclk1, hs1, vs1, blank1, sync1;
    logic [7:0]  r1, g1, b1;
    logic        busy4, fs4, vclk4, hs4, vs4, blank4, sync4;
    logic [7:0]  r4, g4, b4;

    driver_vga_palette u_dut (
        .clock_50(clk), .reset(rst), .data(data1), .chip_select(cs1), .write_enable(we1),
        .busy(busy1), .frame_start(fs1), .VGA_CLK(vclk1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK(blank1), .VGA_SYNC(sync1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1)
    );

    driver_vga_palette #(.BPP(4)) u_dut4 (
        .clock_50(clk), .reset(rst), .data(data4), .chip_select(cs4), .write_enable(we4),
        .busy(busy4), .frame_start(fs4), .VGA_CLK(vclk4), .VGA_HS(hs4), .VGA_VS(vs4),
        .VGA_BLANK(blank4), .VGA_SYNC(sync4), .VGA_R(r4), .VGA_G(g4), .VGA_B(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    typedef struct { int x; int y; logic [23:0] rgb; } probe_t;
    probe_t q1[$];
    probe_t q4[$];

    task automatic push1(input int x, input int y, input logic [23:0] rgb);
        probe_t p; p.x = x; p.y = y; p.rgb = rgb; q1.push_back(p);
    endtask
    task automatic push4(input int x, input int y, input logic [23:0] rgb);
        probe_t p; p.x = x; p.y = y; p.rgb = rgb; q4.push_back(p);
    endtask

    // Pixel position comes from VGA_BLANK edges; one sample per pixel tick.
    int   mon_x, mon_y;
    logic prev_blank;
    always @(negedge clk) begin
        probe_t p;
        if (rst) begin
            mon_y = -1; mon_x = 0; prev_blank = 1'b0;
        end else if (!vclk1) begin
            if (blank1 && !prev_blank) begin mon_y++; mon_x = 0; end
            else if (blank1) mon_x++;
            prev_blank = blank1;
            if (blank1 && q1.size() > 0 && q1[0].x == mon_x && q1[0].y == mon_y) begin
                p = q1.pop_front();
                chk($sformatf("pix1(%0d,%0d)", p.x, p.y), {8'h0, r1, g1, b1}, {8'h0, p.rgb});
            end
            if (blank1 && q4.size() > 0 && q4[0].x == mon_x && q4[0].y == mon_y) begin
                p = q4.pop_front();
                chk($sformatf("pix4(%0d,%0d)", p.x, p.y), {8'h0, r4, g4, b4}, {8'h0, p.rgb});
            end
        end
    end

    task automatic cmd1(input logic [31:0] d);
        data1 = d; cs1 = 1'b1; we1 = 1'b1;
        @(negedge clk);
        cs1 = 1'b0; we1 = 1'b0;
    endtask
    task automatic cmd4(input logic [31:0] d);
        data4 = d; cs4 = 1'b1; we4 = 1'b1;
        @(negedge clk);
        cs4 = 1'b0; we4 = 1'b0;
    endtask

    // Called on the negedge right after a clear strobe: busy must already be high.
    task automatic busy_len(input string nm, input bit sel4);
        int n = 0;
        while ((sel4 ? busy4 : busy1) && n < 6000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'd4800);
    endtask

    task automatic wait_line(input int n);
        int t = 0;
        while (mon_y < n && t < 100000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("reach_line%0d", n), 32'(mon_y >= n), 32'd1);
    endtask

    // Called right after reset is released on a negedge.
    task automatic check_fs(input string nm);
        int first = -1, cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (fs1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk({nm, "_pos"}, 32'(first), 32'd2);
        chk({nm, "_cnt"}, 32'(cnt), 32'd1);
    endtask

    task automatic hs_check();
        int t = 0, f1 = -1, rs1 = -1, f2 = -1;
        logic prev = 1'b1;
        while (t < 5000 && f2 < 0) begin
            @(negedge clk);
            t++;
            if (prev && !hs1) begin
                if (f1 < 0) f1 = t; else f2 = t;
            end
            if (!prev && hs1 && f1 >= 0 && rs1 < 0) rs1 = t;
            prev = hs1;
        end
        chk("hs_period", 32'(f2 - f1), 32'd1600);
        chk("hs_low", 32'(rs1 - f1), 32'd192);
        chk("vs_idle", {31'h0, vs1}, 32'd1);
    endtask

    task automatic seq4();
        cmd4(32'h4F12_3456);               // palette 15 = 123456
        cmd4(32'h8000_000F);               // clear with 15
        busy_len("busy4_len", 1'b1);
        cmd4(32'h0002_0503);               // cell (2,5) = 3 -> reset palette white
        push4(0, 8, 24'h123456);
        push4(40, 16, 24'hFFFFFF);
        push4(48, 16, 24'h123456);
    endtask

    task automatic seq1();
        cmd1(32'h8000_0000);               // clear with 0
        chk("busy_rise", {31'h0, busy1}, 32'd1);
        fork
            busy_len("busy1_len0", 1'b0);
            begin
                repeat (100) @(negedge clk);
                cmd1(32'h0002_0601);       // dropped: clear running
            end
        join
        cmd1(32'h0002_0501);               // cell (2,5) = 1
        cmd1(32'h0002_5001);               // column 80: ignored
        cmd1(32'h003C_0501);               // row 60: ignored
        cmd1(32'hC002_0701);               // reserved opcode
        push1(40, 15, 24'h000000);
        push1(39, 16, 24'h000000);
        push1(40, 16, 24'hFFFFFF);
        push1(47, 16, 24'hFFFFFF);
        push1(48, 16, 24'h000000);
        push1(56, 16, 24'h000000);
        push1(47, 23, 24'hFFFFFF);
        push1(0, 24, 24'h000000);
        push1(40, 24, 24'h000000);

        wait_line(25);
        cmd1(32'h4300_FF00);               // index 3 folds to 1 when BPP=1
        cmd1(32'h0004_0501);
        push1(40, 32, 24'h00FF00);
        push1(48, 32, 24'h000000);
        push1(47, 33, 24'h00FF00);

        wait_line(34);
        cmd1(32'h8000_0001);               // clear with 1
        fork
            busy_len("busy1_len1", 1'b0);
            begin
                repeat (100) @(negedge clk);
                cmd1(32'h0006_0000);       // dropped
                cmd1(32'h41FF_FFFF);       // palette accepted during clear
            end
        join
        push1(0, 40, 24'hFFFFFF);
        push1(320, 41, 24'hFFFFFF);
        push1(639, 42, 24'hFFFFFF);
    endtask

    initial begin
        rst = 1'b1;
        data1 = '0; cs1 = 1'b0; we1 = 1'b0;
        data4 = '0; cs4 = 1'b0; we4 = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_sync", {28'h0, hs1, vs1, blank1, sync1}, 32'hC);
        chk("rst_rgb", {8'h0, r1, g1, b1}, 32'h0);
        chk("rst_misc", {29'h0, vclk1, busy1, fs1}, 32'h0);
        rst = 1'b0;
        fork
            check_fs("fs1");
            hs_check();
            seq4();
            seq1();
        join

        wait_line(43);
        cmd1(32'h8000_0000);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'h0, busy1}, 32'd0);
        chk("rst_mid_sync", {29'h0, hs1, vs1, blank1}, 32'h6);
        repeat (3) @(negedge clk);
        push1(0, 0, 24'h000000);
        push1(639, 0, 24'hFFFFFF);
        rst = 1'b0;
        check_fs("fs2");
        wait_line(1);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
